// File: rtl/rvfi_csr_shadow_check.sv
// Shadow-tracks one plain-storage CSR over the RVFI stream and flags read mismatches, order gaps and bad writes.
// Latency: checks are combinational on the event; fail/shadow/order state update on the next clock edge.
// Backpressure: none; a pure observer that accepts every retirement presented.
module rvfi_csr_shadow_check #(
    parameter int                XLEN        = 32,
    parameter int                ORDER_W     = 64,
    parameter logic [XLEN-1:0]   LEGAL_WMASK = {XLEN{1'b1}},
    parameter bit                CHECK_ORDER = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               check,
    input  logic               rvfi_valid,
    input  logic [ORDER_W-1:0] rvfi_order,
    input  logic               rvfi_trap,
    input  logic [XLEN-1:0]    rvfi_csr_rmask,
    input  logic [XLEN-1:0]    rvfi_csr_wmask,
    input  logic [XLEN-1:0]    rvfi_csr_rdata,
    input  logic [XLEN-1:0]    rvfi_csr_wdata,
    output logic               fail,
    output logic [2:0]         fail_code,
    output logic [ORDER_W-1:0] fail_order,
    output logic [15:0]        retired
);

    localparam logic [2:0] CODE_NONE   = 3'd0;
    localparam logic [2:0] CODE_ORDER  = 3'd1;
    localparam logic [2:0] CODE_TRAPWR = 3'd2;
    localparam logic [2:0] CODE_ILLWR  = 3'd3;
    localparam logic [2:0] CODE_RDMIS  = 3'd4;

    logic [XLEN-1:0]    shadow;
    logic [XLEN-1:0]    known;
    logic [ORDER_W-1:0] exp_order;
    logic               have_order;

    logic               err_order;
    logic               err_trapwr;
    logic               err_illwr;
    logic               err_rdmis;
    logic [2:0]         err_code;
    logic [XLEN-1:0]    learn_mask;
    logic [XLEN-1:0]    shadow_nxt;

    always_comb begin
        err_order  = CHECK_ORDER && have_order && (rvfi_order != exp_order);
        err_trapwr = rvfi_trap && (rvfi_csr_wmask != '0);
        err_illwr  = (rvfi_csr_wmask & ~LEGAL_WMASK) != '0;
        err_rdmis  = ((rvfi_csr_rdata ^ shadow) & rvfi_csr_rmask & known) != '0;

        err_code = CODE_NONE;
        if (err_order)
            err_code = CODE_ORDER;
        else if (err_trapwr)
            err_code = CODE_TRAPWR;
        else if (err_illwr)
            err_code = CODE_ILLWR;
        else if (err_rdmis)
            err_code = CODE_RDMIS;

        // Written bits take wdata; read-only bits learn rdata; untouched bits hold.
        learn_mask = rvfi_csr_rmask & ~rvfi_csr_wmask;
        shadow_nxt = (shadow & ~(rvfi_csr_rmask | rvfi_csr_wmask))
                   | (rvfi_csr_rdata & learn_mask)
                   | (rvfi_csr_wdata & rvfi_csr_wmask);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fail       <= 1'b0;
            fail_code  <= CODE_NONE;
            fail_order <= '0;
            retired    <= '0;
            shadow     <= '0;
            known      <= '0;
            exp_order  <= '0;
            have_order <= 1'b0;
        end else if (rvfi_valid) begin
            if (check && !fail && (err_code != CODE_NONE)) begin
                fail       <= 1'b1;
                fail_code  <= err_code;
                fail_order <= rvfi_order;
            end
            shadow     <= shadow_nxt;
            known      <= known | rvfi_csr_rmask | rvfi_csr_wmask;
            exp_order  <= rvfi_order + {{(ORDER_W-1){1'b0}}, 1'b1};
            have_order <= 1'b1;
            if (retired != 16'hFFFF)
                retired <= retired + 16'd1;
        end
    end

`ifdef FORMAL
    always_comb begin
        if (!reset && rvfi_valid && check) begin
            a_order:  assert (!err_order);
            a_trapwr: assert (!err_trapwr);
            a_illwr:  assert (!err_illwr);
            a_rdmis:  assert (!err_rdmis);
        end
    end
`endif

endmodule

// File: tb/tb_rvfi_csr_shadow_check.sv
// Directed bench for rvfi_csr_shadow_check: a vector table of per-cycle stimulus and expected outputs,
// plus hand sequences for a restricted-write-mask instance and retired-counter saturation.
module tb_rvfi_csr_shadow_check;

    logic        clock = 1'b0;
    logic        reset;
    logic        check;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic        rvfi_trap;
    logic [31:0] rvfi_csr_rmask;
    logic [31:0] rvfi_csr_wmask;
    logic [31:0] rvfi_csr_rdata;
    logic [31:0] rvfi_csr_wdata;

    logic        fail,  fail2;
    logic [2:0]  fail_code, fail_code2;
    logic [63:0] fail_order, fail_order2;
    logic [15:0] retired, retired2;

    int nvec = 0;
    int nmis = 0;

    always #5 clock = ~clock;

    rvfi_csr_shadow_check dut (
        .clock(clock), .reset(reset), .check(check),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_trap(rvfi_trap),
        .rvfi_csr_rmask(rvfi_csr_rmask), .rvfi_csr_wmask(rvfi_csr_wmask),
        .rvfi_csr_rdata(rvfi_csr_rdata), .rvfi_csr_wdata(rvfi_csr_wdata),
        .fail(fail), .fail_code(fail_code), .fail_order(fail_order), .retired(retired)
    );

    rvfi_csr_shadow_check #(.LEGAL_WMASK(32'h0000FFFF)) dut2 (
        .clock(clock), .reset(reset), .check(check),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_trap(rvfi_trap),
        .rvfi_csr_rmask(rvfi_csr_rmask), .rvfi_csr_wmask(rvfi_csr_wmask),
        .rvfi_csr_rdata(rvfi_csr_rdata), .rvfi_csr_wdata(rvfi_csr_wdata),
        .fail(fail2), .fail_code(fail_code2), .fail_order(fail_order2), .retired(retired2)
    );

    typedef struct {
        logic        rst, chk, vld;
        logic [63:0] ord;
        logic        trap;
        logic [31:0] rm, wm, rd, wd;
        logic        e_fail;
        logic [2:0]  e_code;
        logic [63:0] e_ord;
        logic [15:0] e_ret;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic chk, input logic vld,
                                input logic [63:0] ord, input logic trap,
                                input logic [31:0] rm, input logic [31:0] wm,
                                input logic [31:0] rd, input logic [31:0] wd,
                                input logic ef, input logic [2:0] ec,
                                input logic [63:0] eo, input logic [15:0] er);
        vec_t v;
        v.rst = rst; v.chk = chk; v.vld = vld; v.ord = ord; v.trap = trap;
        v.rm = rm; v.wm = wm; v.rd = rd; v.wd = wd;
        v.e_fail = ef; v.e_code = ec; v.e_ord = eo; v.e_ret = er;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic chk, input logic vld, input logic [63:0] ord,
                         input logic trap, input logic [31:0] rm, input logic [31:0] wm,
                         input logic [31:0] rd, input logic [31:0] wd);
        reset = rst; check = chk; rvfi_valid = vld; rvfi_order = ord; rvfi_trap = trap;
        rvfi_csr_rmask = rm; rvfi_csr_wmask = wm; rvfi_csr_rdata = rd; rvfi_csr_wdata = wd;
        @(posedge clock);
        #1;
    endtask

    task automatic chk2(input string name, input logic ef, input logic [2:0] ec,
                        input logic [63:0] eo, input logic [15:0] er);
        cmp({name, ".fail2"}, {63'd0, fail2}, {63'd0, ef});
        cmp({name, ".code2"}, {61'd0, fail_code2}, {61'd0, ec});
        cmp({name, ".order2"}, fail_order2, eo);
        cmp({name, ".retired2"}, {48'd0, retired2}, {48'd0, er});
    endtask

    localparam logic [31:0] ALL = 32'hFFFF_FFFF;

    initial begin
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);

        // rst chk vld order trap rmask wmask rdata wdata | fail code forder retired
        tbl.push_back(mk(1,1,0, 0, 0, 0,   0,   0, 0,                  0,0, 0,0));
        tbl.push_back(mk(1,1,1, 7, 0, 0,   ALL, 0, 32'h0,              0,0, 0,0));
        tbl.push_back(mk(0,1,1, 0, 0, 0,   0,   0, 0,                  0,0, 0,1));
        tbl.push_back(mk(0,1,1, 1, 0, 0,   0,   0, 0,                  0,0, 0,2));
        tbl.push_back(mk(0,1,1, 2, 0, 0,   0,   0, 0,                  0,0, 0,3));
        tbl.push_back(mk(0,1,1, 3, 0, 0,   0,   0, 0,                  0,0, 0,4));
        tbl.push_back(mk(0,1,0, 9, 1, ALL, ALL, 1, 2,                  0,0, 0,4));
        tbl.push_back(mk(0,1,1, 4, 0, ALL, 0,   32'h1234_5678, 0,      0,0, 0,5));
        tbl.push_back(mk(0,1,1, 5, 0, 0,   ALL, 0, 32'hDEAD_BEEF,      0,0, 0,6));
        tbl.push_back(mk(0,1,1, 6, 0, ALL, 0,   32'hDEAD_BEEF, 0,      0,0, 0,7));
        tbl.push_back(mk(0,1,1, 7, 0, ALL, 0,   32'hDEAD_BEEE, 0,      1,4, 7,8));
        tbl.push_back(mk(0,1,1, 8, 1, 0,   32'hF, 0, 0,                1,4, 7,9));
        tbl.push_back(mk(0,1,1, 20,0, 0,   0,   0, 0,                  1,4, 7,10));
        // order gap, with check on and then off
        tbl.push_back(mk(1,1,1, 50,0, 0,   0,   0, 0,                  0,0, 0,0));
        tbl.push_back(mk(0,1,1, 10,0, 0,   0,   0, 0,                  0,0, 0,1));
        tbl.push_back(mk(0,1,1, 12,0, 0,   0,   0, 0,                  1,1, 12,2));
        tbl.push_back(mk(1,1,0, 0, 0, 0,   0,   0, 0,                  0,0, 0,0));
        tbl.push_back(mk(0,0,1, 10,0, 0,   0,   0, 0,                  0,0, 0,1));
        tbl.push_back(mk(0,0,1, 12,0, 0,   0,   0, 0,                  0,0, 0,2));
        tbl.push_back(mk(0,1,1, 13,0, 0,   0,   0, 0,                  0,0, 0,3));
        tbl.push_back(mk(0,1,1, 14,1, 0,   32'hF, 0, 5,                1,2, 14,4));
        // trapped write as the baseline event
        tbl.push_back(mk(1,1,0, 0, 0, 0,   0,   0, 0,                  0,0, 0,0));
        tbl.push_back(mk(0,1,1, 3, 1, 0,   32'hF, 0, 0,                1,2, 3,1));
        // ORDER outranks TRAPWR
        tbl.push_back(mk(1,1,0, 0, 0, 0,   0,   0, 0,                  0,0, 0,0));
        tbl.push_back(mk(0,1,1, 0, 0, 0,   0,   0, 0,                  0,0, 0,1));
        tbl.push_back(mk(0,1,1, 2, 1, 0,   1,   0, 0,                  1,1, 2,2));
        // partial knowledge then read learning of the upper bits
        tbl.push_back(mk(1,1,0, 0, 0, 0,   0,   0, 0,                  0,0, 0,0));
        tbl.push_back(mk(0,1,1, 0, 0, 0,   32'hFF, 0, 32'h12,          0,0, 0,1));
        tbl.push_back(mk(0,1,1, 1, 0, ALL, 0,   32'hABCD_0012, 0,      0,0, 0,2));
        tbl.push_back(mk(0,1,1, 2, 0, ALL, 0,   32'h0000_0012, 0,      1,4, 2,3));
        // write wins over read learning on the same bit
        tbl.push_back(mk(1,1,0, 0, 0, 0,   0,   0, 0,                  0,0, 0,0));
        tbl.push_back(mk(0,1,1, 0, 0, ALL, ALL, 32'h1111_1111, 32'h2222_2222, 0,0, 0,1));
        tbl.push_back(mk(0,1,1, 1, 0, ALL, 0,   32'h2222_2222, 0,      0,0, 0,2));
        tbl.push_back(mk(0,1,1, 2, 0, ALL, 0,   32'h1111_1111, 0,      1,4, 2,3));
        // trapped write is still learned (check off during the trap)
        tbl.push_back(mk(1,1,0, 0, 0, 0,   0,   0, 0,                  0,0, 0,0));
        tbl.push_back(mk(0,0,1, 0, 1, 0,   ALL, 0, 32'hAAAA_0000,      0,0, 0,1));
        tbl.push_back(mk(0,1,1, 1, 0, ALL, 0,   32'hAAAA_0000, 0,      0,0, 0,2));
        tbl.push_back(mk(0,1,1, 2, 0, ALL, 0,   32'h0000_0000, 0,      1,4, 2,3));
        // order wrap, then a repeated index
        tbl.push_back(mk(1,1,0, 0, 0, 0,   0,   0, 0,                  0,0, 0,0));
        tbl.push_back(mk(0,1,1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0, 0,0, 0,1));
        tbl.push_back(mk(0,1,1, 0, 0, 0,   0,   0, 0,                  0,0, 0,2));
        tbl.push_back(mk(0,1,1, 1, 0, 0,   0,   0, 0,                  0,0, 0,3));
        tbl.push_back(mk(0,1,1, 1, 0, 0,   0,   0, 0,                  1,1, 1,4));
        // reset with fail set and a valid event in the same cycle
        tbl.push_back(mk(1,1,1, 55,1, ALL, ALL, 0, 32'h5555_5555,      0,0, 0,0));
        tbl.push_back(mk(0,1,1, 99,0, 0,   0,   0, 0,                  0,0, 0,1));
        tbl.push_back(mk(0,1,1, 100,0,ALL, 0,   32'h7777_7777, 0,      0,0, 0,2));

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            string tag;
            v = tbl[i];
            tag = $sformatf("row%0d", i);
            drive(v.rst, v.chk, v.vld, v.ord, v.trap, v.rm, v.wm, v.rd, v.wd);
            cmp({tag, ".fail"}, {63'd0, fail}, {63'd0, v.e_fail});
            cmp({tag, ".code"}, {61'd0, fail_code}, {61'd0, v.e_code});
            cmp({tag, ".order"}, fail_order, v.e_ord);
            cmp({tag, ".retired"}, {48'd0, retired}, {48'd0, v.e_ret});
        end

        // Restricted write mask instance: TRAPWR beats ILLWR
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 1, 0, 32'h0001_0000, 0, 0);
        chk2("trap_ill", 1, 2, 0, 1);
        // plain illegal write
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 4, 0, 0, 32'h0001_0000, 0, 0);
        chk2("illwr", 1, 3, 4, 1);
        // legal write, then ILLWR beats RDMISMATCH
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 32'h0000_FFFF, 0, 32'h1234);
        chk2("legalwr", 0, 0, 0, 1);
        drive(0, 1, 1, 1, 0, 32'h0000_FFFF, 32'h0001_0000, 32'h0, 0);
        chk2("ill_rd", 1, 3, 1, 2);

        // retired saturates at 16'hFFFF
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65535; i++)
            drive(0, 1, 1, 64'(i), 0, 0, 0, 0, 0);
        cmp("sat.retired", {48'd0, retired}, 64'hFFFF);
        drive(0, 1, 1, 64'd65535, 0, 0, 0, 0, 0);
        cmp("sat.hold", {48'd0, retired}, 64'hFFFF);
        cmp("sat.fail", {63'd0, fail}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
